keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_pkg.sv | 37 +++
 rtl/stable_counter.sv | 38 +++
 rtl/keypad_scan.sv | 171 +++++++++++++++++
 tb/tb_keypad_scan.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// ============================================================================
// Module      : keypad_pkg
// Description : Shared FSM state type, key map and timing defaults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    localparam int c_SCAN_DIV        = 48000;
    localparam int c_DEBOUNCE_CYCLES = 960000;

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    // Indexed by {row, col}; row 3 carries '*' as E and '#' as F.
    localparam logic [15:0][3:0] c_KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [1:0] lowest_low(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stable_counter.sv
// ============================================================================
// Module      : stable_counter
// Description : Saturating run-length counter of an input held at TARGET_LEVEL.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stable_counter #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CW              = 5,
    parameter bit TARGET_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_level,
    output logic o_done
);

    localparam logic [CW-1:0] c_TERMINAL = CW'(DEBOUNCE_CYCLES);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (!i_en || (i_level != TARGET_LEVEL)) begin
            r_count <= '0;
        end else if (r_count != c_TERMINAL) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_done = (r_count == c_TERMINAL);

endmodule

`default_nettype wire

// File: rtl/keypad_scan.sv
// ============================================================================
// Module      : keypad_scan
// Description : 4x4 keypad row scanner with press/release debounce and a
//               two-digit history. Define KEYPAD_SYNC_EN for a 2-flop cols sync.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = c_SCAN_DIV,
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] value1,
    output logic [3:0] value2,
    output logic       new_key
);

    localparam int c_CW = $clog2((SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES) + 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(SCAN_DIV - 1);

    logic [3:0] w_cols;

`ifdef KEYPAD_SYNC_EN
    logic [3:0] r_cols_meta;
    logic [3:0] r_cols_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cols_meta <= 4'hF;
            r_cols_sync <= 4'hF;
        end else begin
            r_cols_meta <= cols;
            r_cols_sync <= r_cols_meta;
        end
    end

    assign w_cols = r_cols_sync;
`else
    logic [3:0] r_cols_q;

    always_ff @(posedge clk) begin
        if (!reset) r_cols_q <= 4'hF;
        else        r_cols_q <= cols;
    end

    assign w_cols = r_cols_q;
`endif

    state_t          r_state,  w_state_nx;
    logic [1:0]      r_idx,    w_idx_nx;
    logic [1:0]      r_col,    w_col_nx;
    logic [c_CW-1:0] r_div,    w_div_nx;
    logic [3:0]      r_value1, w_value1_nx;
    logic [3:0]      r_value2, w_value2_nx;
    logic            r_new_key, w_new_key_nx;
    logic            w_col_lvl;
    logic            w_press_done;
    logic            w_release_done;

    // Only the latched column is watched once a key is found.
    assign w_col_lvl = w_cols[r_col];

    stable_counter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CW              (c_CW),
        .TARGET_LEVEL    (1'b0)
    ) u_press_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_en    (r_state == S_DEBOUNCE),
        .i_level (w_col_lvl),
        .o_done  (w_press_done)
    );

    stable_counter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CW              (c_CW),
        .TARGET_LEVEL    (1'b1)
    ) u_release_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_en    (r_state == S_RELEASE),
        .i_level (w_col_lvl),
        .o_done  (w_release_done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_SCAN;
            r_idx     <= '0;
            r_col     <= '0;
            r_div     <= '0;
            r_value1  <= '0;
            r_value2  <= '0;
            r_new_key <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_idx     <= w_idx_nx;
            r_col     <= w_col_nx;
            r_div     <= w_div_nx;
            r_value1  <= w_value1_nx;
            r_value2  <= w_value2_nx;
            r_new_key <= w_new_key_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_idx_nx     = r_idx;
        w_col_nx     = r_col;
        w_div_nx     = r_div;
        w_value1_nx  = r_value1;
        w_value2_nx  = r_value2;
        w_new_key_nx = 1'b0;

        case (r_state)
            S_SCAN: begin
                if (r_div == c_LAST) begin
                    w_div_nx = '0;
                    if (w_cols != 4'hF) begin
                        w_col_nx   = lowest_low(w_cols);
                        w_state_nx = S_DEBOUNCE;
                    end else begin
                        w_idx_nx = r_idx + 2'd1;
                    end
                end else begin
                    w_div_nx = r_div + c_CW'(1);
                end
            end
            S_DEBOUNCE: begin
                if (w_press_done) begin
                    w_value1_nx  = r_value2;
                    w_value2_nx  = c_KEY_MAP[{r_idx, r_col}];
                    w_new_key_nx = 1'b1;
                    w_state_nx   = S_HELD;
                end else if (w_col_lvl) begin
                    w_idx_nx   = r_idx + 2'd1;
                    w_div_nx   = '0;
                    w_state_nx = S_SCAN;
                end
            end
            S_HELD: begin
                if (w_col_lvl) w_state_nx = S_RELEASE;
            end
            S_RELEASE: begin
                if (w_release_done) begin
                    w_idx_nx   = r_idx + 2'd1;
                    w_div_nx   = '0;
                    w_state_nx = S_SCAN;
                end else if (!w_col_lvl) begin
                    w_state_nx = S_HELD;
                end
            end
            default: w_state_nx = S_SCAN;
        endcase
    end

    assign rows    = ~(4'b0001 << r_idx);
    assign value1  = r_value1;
    assign value2  = r_value2;
    assign new_key = r_new_key;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan.sv
// ============================================================================
// Module      : tb_keypad_scan
// Description : Self-checking bench for keypad_scan with a keypad matrix model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [3:0]  value1;
    logic [3:0]  value2;
    logic        new_key;
    logic [15:0] keys;

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  code;
    } vec_t;

    vec_t       tbl [18];
    int         n_vec = 0;
    int         n_err = 0;
    int         pulses = 0;
    logic [3:0] m_v1;
    logic [3:0] m_v2;

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cols    (cols),
        .rows    (rows),
        .value1  (value1),
        .value2  (value2),
        .new_key (new_key)
    );

    // Pressed key at (r,c) pulls column c low while row r is driven low.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !rows[r]) cols[c] = 1'b0;
    end

    function automatic logic [15:0] key(input int r, input int c);
        return 16'(1) << (r*4 + c);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (new_key === 1'b1) pulses++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        keys  = '0;
        step(3);
        reset = 1'b1;
        m_v1  = 4'h0;
        m_v2  = 4'h0;
    endtask

    // One press/release: optional early bounce, then a long stable hold.
    task automatic episode(input logic [15:0] k, input logic [3:0] code,
                           input int o, input int g, input string nm);
        int p0;
        p0   = pulses;
        keys = k;
        step(o);
        keys = '0;
        step(g);
        keys = k;
        step(45);
        keys = '0;
        step(20);
        m_v1 = m_v2;
        m_v2 = code;
        check({nm, " pulses"}, 32'(pulses - p0), 32'd1);
        check({nm, " value2"}, 32'(value2), 32'(m_v2));
        check({nm, " value1"}, 32'(value1), 32'(m_v1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int         p0;
        int         ki;
        logic [3:0] e_rows;

        tbl[0]  = '{key(1,2), 4'h6};  tbl[1]  = '{key(3,1), 4'h0};
        tbl[2]  = '{key(0,0), 4'h1};  tbl[3]  = '{key(0,1), 4'h2};
        tbl[4]  = '{key(0,2), 4'h3};  tbl[5]  = '{key(0,3), 4'hA};
        tbl[6]  = '{key(1,0), 4'h4};  tbl[7]  = '{key(1,1), 4'h5};
        tbl[8]  = '{key(1,3), 4'hB};  tbl[9]  = '{key(2,0), 4'h7};
        tbl[10] = '{key(2,1), 4'h8};  tbl[11] = '{key(2,2), 4'h9};
        tbl[12] = '{key(2,3), 4'hC};  tbl[13] = '{key(3,0), 4'hE};
        tbl[14] = '{key(3,2), 4'hF};  tbl[15] = '{key(3,3), 4'hD};
        tbl[16] = '{key(2,1) | key(2,3), 4'h8};
        tbl[17] = '{key(0,2) | key(0,3), 4'h3};

        reset = 1'b0;
        keys  = '0;
        step(3);
        check("reset rows", 32'(rows), 32'hE);
        check("reset value1", 32'(value1), 32'h0);
        check("reset value2", 32'(value2), 32'h0);
        check("reset new_key", 32'(new_key), 32'h0);

        reset = 1'b1;
        for (int k = 0; k < 17; k++) begin
            if (k > 0) step(1);
            e_rows = ~(4'b0001 << ((k / 4) % 4));
            check("scan rows", 32'(rows), 32'(e_rows));
        end

        // Short bounce enters debounce then aborts; the later stable press commits.
        do_reset();
        p0   = pulses;
        keys = key(0,0);
        step(3);
        keys = '0;
        step(1);
        keys = key(0,0);
        step(12);
        check("bounce no commit", 32'(pulses - p0), 32'd0);
        step(40);
        keys = '0;
        step(20);
        check("bounce pulses", 32'(pulses - p0), 32'd1);
        check("bounce value2", 32'(value2), 32'h1);
        check("bounce value1", 32'(value1), 32'h0);

        // Reset during the fifth debounce cycle discards the press.
        do_reset();
        p0   = pulses;
        keys = key(0,0);
        step(8);
        reset = 1'b0;
        keys  = '0;
        step(3);
        check("midrst pulses", 32'(pulses - p0), 32'd0);
        check("midrst value1", 32'(value1), 32'h0);
        check("midrst value2", 32'(value2), 32'h0);
        check("midrst rows", 32'(rows), 32'hE);
        reset = 1'b1;
        step(30);
        check("midrst after", 32'(pulses - p0), 32'd0);

        do_reset();
        for (int i = 0; i < 18; i++)
            episode(tbl[i].keys, tbl[i].code, 0, 0, "table");

        for (int i = 0; i < 12; i++) begin
            ki = $urandom_range(0, 15);
            episode(tbl[ki].keys, tbl[ki].code, $urandom_range(0, 19), $urandom_range(1, 4), "random");
        end

        // Second key in another row is ignored until the first is released.
        p0   = pulses;
        keys = key(1,1);
        step(45);
        m_v1 = m_v2;
        m_v2 = 4'h5;
        check("held5 pulses", 32'(pulses - p0), 32'd1);
        check("held5 value2", 32'(value2), 32'(m_v2));
        keys = key(1,1) | key(2,2);
        step(30);
        check("held9 ignored", 32'(pulses - p0), 32'd1);
        keys = key(2,2);
        step(60);
        m_v1 = m_v2;
        m_v2 = 4'h9;
        check("after9 pulses", 32'(pulses - p0), 32'd2);
        check("after9 value2", 32'(value2), 32'(m_v2));
        check("after9 value1", 32'(value1), 32'(m_v1));
        keys = '0;
        step(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
